// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: FSM state encoding,
// default halt encoding and the PC increment.
package seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned RET_W   = 16;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
  localparam logic [STATE_W-1:0] S_EXEC  = 3'd3;
  localparam logic [STATE_W-1:0] S_NEXT  = 3'd4;
  localparam logic [STATE_W-1:0] S_HALT  = 3'd5;

  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [INSTR_W-1:0] PC_INC            = 32'd4;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector.
// Ports: clk, rst (async, active-high), sig (level in), rise (sig & ~sig_q).
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  // Previous-cycle copy of the input level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/step_sequencer.sv
// Instruction sequencer: owns the PC and walks the datapath through
// fetch / load / execute / advance, absorbing the instruction-memory latency.
// Ports:
//   clk, rst       system clock, async active-high reset
//   step, run      debounced single-step level, free-run enable
//   instr_q        instruction-memory read data
//   imem_addr      word address (pc[ADDR_W+1:2])
//   pc, ir         program counter, latched instruction
//   ir_valid       ir holds a loaded instruction
//   rf_we          register-file write strobe (one cycle per retire)
//   halted         sticky halt flag
//   instret        retired-instruction count
module step_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned IMEM_LATENCY = 1,
  parameter int unsigned ADDR_W       = 8,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              run,
  input  logic [31:0]       instr_q,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic              rf_we,
  output logic              halted,
  output logic [15:0]       instret
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LATENCY - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               step_rise;
  logic               is_halt;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .sig  (step),
    .rise (step_rise)
  );

  assign is_halt   = (ir == HALT_WORD);
  assign imem_addr = pc[ADDR_W+1:2];
  // Write strobe decoded from state so it lines up exactly with EXEC.
  assign rf_we     = (state == S_EXEC) && !is_halt;

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic; step_rise is only looked at in IDLE, so it is dropped elsewhere.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      S_IDLE:  if (run || step_rise) state_d = S_FETCH;
      S_FETCH: begin
        if (cnt == CNT_LAST) state_d = S_LOAD;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  state_d = is_halt ? S_HALT : S_NEXT;
      S_NEXT:  state_d = run ? S_FETCH : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: IR capture, halt flag, PC advance and retire count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      instret  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          ir       <= instr_q;
          ir_valid <= 1'b1;
        end
        S_EXEC: if (is_halt) halted <= 1'b1;
        S_NEXT: begin
          pc      <= pc + PC_INC;
          instret <= instret + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
